// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Opcode encoding, FSM state type and lane helper functions for
//            the load/store unit master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'h0,
        OP_LH  = 4'h1,
        OP_LW  = 4'h2,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic logic op_known(logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_known = 1'b1;
            default:             op_known = 1'b0;
        endcase
    endfunction

    // Low two opcode bits carry the access size for every legal opcode.
    function automatic lsu_size_e op_size(logic [3:0] op);
        op_size = lsu_size_e'(op[1:0]);
    endfunction

    // Misaligned halves/words are forced onto their natural boundary.
    function automatic logic [1:0] align_lo(lsu_size_e size, logic [1:0] lo);
        case (size)
            SZ_BYTE: align_lo = lo;
            SZ_HALF: align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] gen_be(lsu_size_e size, logic [1:0] lo);
        case (size)
            SZ_BYTE: gen_be = 4'b0001 << lo;
            SZ_HALF: gen_be = 4'b0011 << {lo[1], 1'b0};
            default: gen_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(logic [31:0] rdata, lsu_size_e size,
                                                logic is_unsigned, logic [1:0] lo);
        logic [31:0] sh;
        sh = rdata >> {lo, 3'b000};
        case (size)
            SZ_BYTE: extend_load = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
            SZ_HALF: extend_load = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
            default: extend_load = rdata;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_master_if.sv
// ============================================================================
// Module   : lsu_master_if
// Brief    : Request, memory and write-back signal bundle of the LSU master.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lsu_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              err;
    logic              busy;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rd,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_rd, wb_data, err, busy
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rd,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_rd, wb_data, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Combinational store lane replication, byte enables and load
//            lane extract with sign/zero extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    assign o_be    = gen_be(i_size, i_addr_lo);
    assign o_rdata = extend_load(i_rdata, i_size, i_unsigned, i_addr_lo);

    // Replicating the datum lets memory pick any lane with byte enables alone.
    always_comb begin
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
            SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_master.sv
// ============================================================================
// Module   : lsu_master
// Brief    : Single-outstanding load/store master between EX and memory.
//            Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    lsu_master_if.master lsu_bus
);

    // A zero timeout is meaningless; treat it as a single-cycle window.
    localparam int c_TMO    = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
    localparam int c_CNT_W  = $clog2(c_TMO + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(c_TMO - 1);

    lsu_state_e         r_state;
    logic [3:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [4:0]         r_rd;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_req_ready;
    logic               r_busy;
    logic               r_mem_req_valid;
    logic               r_wb_valid;
    logic [4:0]         r_wb_rd;
    logic [31:0]        r_wb_data;
    logic               r_err;

    lsu_size_e   w_size;
    logic [1:0]  w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_op_known;
    logic        w_trap;

    assign w_op_known = op_known(lsu_bus.req_op);

`ifdef LSU_MISALIGN_TRAP_EN
    lsu_size_e w_req_size;
    assign w_req_size = op_size(lsu_bus.req_op);
    assign w_trap = ((w_req_size == SZ_HALF) && lsu_bus.req_addr[0]) ||
                    ((w_req_size == SZ_WORD) && (lsu_bus.req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    assign w_size = op_size(r_op);
    assign w_lo   = align_lo(w_size, r_addr[1:0]);

    lsu_lane_align u_lane_align (
        .i_size     (w_size),
        .i_addr_lo  (w_lo),
        .i_unsigned (r_op[2]),
        .i_wdata    (r_wdata),
        .i_rdata    (lsu_bus.mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_op            <= 4'd0;
            r_addr          <= '0;
            r_wdata         <= 32'd0;
            r_rd            <= 5'd0;
            r_cnt           <= '0;
            r_req_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= 5'd0;
            r_wb_data       <= 32'd0;
            r_err           <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (lsu_bus.req_valid) begin
                        r_op    <= lsu_bus.req_op;
                        r_addr  <= lsu_bus.req_addr;
                        r_wdata <= lsu_bus.req_wdata;
                        r_rd    <= lsu_bus.req_rd;
                        // Rejected requests complete with err and never reach memory.
                        if (!w_op_known || w_trap) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state         <= ST_ISSUE;
                            r_req_ready     <= 1'b0;
                            r_busy          <= 1'b1;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (lsu_bus.mem_req_ready) begin
                        r_state         <= ST_WAIT_RSP;
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (lsu_bus.mem_rsp_valid) begin
                        r_state    <= ST_DONE;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_op[3] ? 5'd0 : r_rd;
                        r_wb_data  <= r_op[3] ? 32'd0 : w_load_data;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_state     <= ST_IDLE;
                        r_err       <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_bus.req_ready     = r_req_ready;
    assign lsu_bus.busy          = r_busy;
    assign lsu_bus.mem_req_valid = r_mem_req_valid;
    assign lsu_bus.mem_we        = r_mem_req_valid & r_op[3];
    assign lsu_bus.mem_be        = r_mem_req_valid ? w_be : 4'b0000;
    assign lsu_bus.mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign lsu_bus.mem_wdata     = w_wdata;
    assign lsu_bus.wb_valid      = r_wb_valid;
    assign lsu_bus.wb_rd         = r_wb_rd;
    assign lsu_bus.wb_data       = r_wb_data;
    assign lsu_bus.err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_master.sv
// ============================================================================
// Module   : tb_lsu_master
// Brief    : Scoreboard bench for lsu_master with a byte-arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    lsu_master_if #(.ADDR_W(32)) bus ();

    lsu_master #(.ADDR_W(32), .TIMEOUT_CYC(255)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lsu_bus (bus)
    );

    typedef struct {
        bit          is_err;
        bit          is_load;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] lanes;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Memory viewed as four byte lanes; loads/stores worked out byte by byte.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [4:0] rd,
                                   input logic [31:0] rdata);
        exp_t        m;
        int          n;
        int          lo2;
        int          off;
        bit          ok;
        bit          ld;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] val;
        ok = 1; ld = 1; sgn = 0; n = 4;
        case (op)
            OP_LB:   begin n = 1; sgn = 1; end
            OP_LH:   begin n = 2; sgn = 1; end
            OP_LW:   begin n = 4; end
            OP_LBU:  begin n = 1; end
            OP_LHU:  begin n = 2; end
            OP_SB:   begin n = 1; ld = 0; end
            OP_SH:   begin n = 2; ld = 0; end
            OP_SW:   begin n = 4; ld = 0; end
            default: begin ok = 0; end
        endcase
        lo2 = int'(addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((lo2 % n) != 0) ok = 0;
`endif
        off = lo2 - (lo2 % n);
        m.is_err  = !ok;
        m.is_load = ld;
        m.rd      = ld ? rd : 5'd0;
        m.maddr   = {addr[31:2], 2'b00};
        m.be      = 4'(((1 << n) - 1) << off);
        for (int b = 0; b < 4; b++) m.lanes[8*b +: 8] = wdata[8*(b % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : 32'((1 << (8*n)) - 1);
        val  = (rdata >> (8*off)) & mask;
        if (sgn && val[8*n-1]) val = val | ~mask;
        m.data = val;
        return m;
    endfunction

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (bus.wb_valid || bus.err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected completion: got wb_valid=%b err=%b, expected none",
                         bus.wb_valid, bus.err);
            end else begin
                e = exp_q.pop_front();
                check("completion err", 32'(bus.err), 32'(e.is_err));
                check("completion wb_valid", 32'(bus.wb_valid), 32'(!e.is_err));
                if (!e.is_err) begin
                    check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                    if (e.is_load) check("wb_data", bus.wb_data, e.data);
                end
            end
        end
    end

    task automatic check_mem(input exp_t m);
        check("mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("mem_addr", bus.mem_addr, m.maddr);
        check("mem_be", 32'(bus.mem_be), 32'(m.be));
        check("mem_we", 32'(bus.mem_we), 32'(!m.is_load));
        check("req_ready in issue", 32'(bus.req_ready), 32'd0);
        check("busy in issue", 32'(bus.busy), 32'd1);
        if (!m.is_load) check("mem_wdata", bus.mem_wdata, m.lanes);
    endtask

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int rdy_dly, input int rsp_dly);
        exp_t m;
        m = model(op, addr, wdata, rd, rdata);
        exp_q.push_back(m);
        @(posedge clk); #1;
        check("req_ready idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_rd = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (m.is_err) begin
            repeat (2) begin
                check("no mem request on error", 32'(bus.mem_req_valid), 32'd0);
                @(posedge clk); #1;
            end
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            check_mem(m);
            if (i == rdy_dly) bus.mem_req_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.mem_req_ready = 1'b0;
        check("mem_be after handshake", 32'(bus.mem_be), 32'd0);
        check("mem_we after handshake", 32'(bus.mem_we), 32'd0);
        repeat (rsp_dly) begin @(posedge clk); #1; end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rdata;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ops [11];
        exp_t       m;
        int         n;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 4'h3, 4'h7, 4'hF};

        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("reset mem_be", 32'(bus.mem_be), 32'd0);
        check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        reset_n = 1'b1;

        // Minimum-latency store: accept c0, issue c1, ack c2, wb c3.
        exp_q.push_back(model(OP_SW, 32'h10, 32'hDEAD_BEEF, 5'd7, 32'd0));
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h10;
        bus.req_wdata = 32'hDEAD_BEEF; bus.req_rd = 5'd7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("sw mem_req_valid c1", 32'(bus.mem_req_valid), 32'd1);
        check("sw mem_be", 32'(bus.mem_be), 32'hF);
        check("sw mem_addr", bus.mem_addr, 32'h10);
        check("sw mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        check("sw mem_req_valid c2", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        check("sw wb_valid c3", 32'(bus.wb_valid), 32'd1);
        check("sw wb_rd", 32'(bus.wb_rd), 32'd0);

        do_txn(OP_LB,  32'h13, 32'd0, 5'd9,  32'h80FF_FF7F, 0, 0);
        do_txn(OP_LBU, 32'h13, 32'd0, 5'd10, 32'h80FF_FF7F, 1, 2);
        do_txn(OP_SH,  32'h22, 32'h0000_ABCD, 5'd1, 32'd0, 1, 1);
        do_txn(OP_LW,  32'h02, 32'd0, 5'd4, 32'h1234_5678, 0, 0);
        do_txn(OP_LH,  32'h102, 32'd0, 5'd5, 32'h8001_7FFF, 2, 0);
        do_txn(4'hB,   32'h30, 32'd0, 5'd6, 32'd0, 0, 0);

        // Stalled issue followed by a response timeout.
        m = model(OP_LW, 32'h40, 32'd0, 5'd2, 32'd0);
        m.is_err = 1'b1;
        exp_q.push_back(m);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = OP_LW; bus.req_addr = 32'h40; bus.req_rd = 5'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_mem(m);
            @(posedge clk); #1;
        end
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        n = 0;
        while (!bus.err && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout cycles", 32'(n), 32'd255);
        check("busy after timeout", 32'(bus.busy), 32'd0);
        check("req_ready after timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        check("err single pulse", 32'(bus.err), 32'd0);

        // Reset while waiting for a response, then a stale response.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = OP_LW; bus.req_addr = 32'h44; bus.req_rd = 5'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("midreset req_ready", 32'(bus.req_ready), 32'd1);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("midreset mem_be", 32'(bus.mem_be), 32'd0);
        check("midreset wb_valid", 32'(bus.wb_valid), 32'd0);
        check("midreset err", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("idle after stale rsp", 32'(bus.busy), 32'd0);

        for (int t = 0; t < 60; t++) begin
            do_txn(ops[$urandom_range(0, 10)], $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 Parameter ADDR_W, default 32: memory address width in bits.
REQ-002 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for mem_rsp_valid before the request is aborted.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1; req_ready  out  1: request handshake from the EX stage; a transfer occurs when both are high on a rising edge.
REQ-006 req_op  in  4: access type (LB, LH, LW, LBU, LHU, SB, SH, SW; encodings in the package).
REQ-007 req_addr  in  ADDR_W  byte address; req_wdata  in  32  store data; req_rd  in  5  load destination register.
REQ-008 mem_req_valid  out  1; mem_req_ready  in  1: memory request handshake.
REQ-009 mem_we  out  1 (1 = store); mem_addr  out  ADDR_W  word-aligned address; mem_be  out  4  byte enables; mem_wdata  out  32  lane-shifted store data.
REQ-010 mem_rsp_valid  in  1  response or acknowledge; mem_rdata  in  32  read word.
REQ-011 wb_valid  out  1  one-cycle completion pulse; wb_rd  out  5; wb_data  out  32  extended load data; err  out  1  one-cycle error pulse; busy  out  1.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
REQ-013 IDLE: req_ready=1; on handshake, capture op, addr, wdata and rd; go to ISSUE.
REQ-014 ISSUE: mem_req_valid=1; hold all mem_* outputs stable until mem_req_ready=1; then go to WAIT_RSP.
REQ-015 WAIT_RSP: on mem_rsp_valid=1, latch the extended data and go to DONE. If TIMEOUT_CYC cycles pass without a response, pulse err and go to IDLE.
REQ-016 DONE: wb_valid=1 for one cycle; wb_rd=captured rd for loads and 0 for stores; return to IDLE.
REQ-017 Minimum latency: request accepted in cycle 0, mem_req_valid high in cycle 1, response in cycle 2, wb_valid in cycle 3.
REQ-018 req_ready=0 in every state except IDLE; busy = not IDLE.
REQ-019 mem_addr = {addr[ADDR_W-1:2], 2'b00}.
REQ-020 mem_be: byte = 0001<<addr[1:0]; half = 0011<<(2*addr[1]); word = 1111.
REQ-021 mem_wdata: byte data replicated on all 4 lanes; half data replicated on both halves; word data unchanged.
REQ-022 Loads select the lane addressed by addr[1:0]. LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
REQ-023 mem_be=0 and mem_we=0 whenever mem_req_valid=0.
REQ-024 A mem_rsp_valid that arrives outside WAIT_RSP is ignored.
REQ-025 A timeout count of 0 is invalid; the timeout counter saturates and resets on entry to WAIT_RSP.
REQ-026 An unknown req_op is accepted and completes with an err pulse, without issuing a memory request.

Reset
REQ-027 While reset_n=0: state=IDLE; req_ready=1; mem_req_valid, wb_valid, err and busy=0; mem_be=0; captured registers and counter=0.
REQ-028 Reset asserted mid-transaction aborts it immediately; no wb_valid or err pulse follows deassertion.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN, when defined, checks alignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, pulses err one cycle after acceptance, issues no memory request and returns to IDLE.
REQ-030 Without LSU_MISALIGN_TRAP_EN, misaligned accesses are forced aligned (half ignores addr[0], word ignores addr[1:0]) and proceed normally.

Structure
REQ-031 Package lsu_pkg holds the req_op encoding enum, the FSM state typedef and the byte-enable/extension helper functions.
REQ-032 One sub-module, lsu_lane_align, holds the combinational store shift, byte-enable generation and load extract/extend.

Verification
REQ-033 SW addr=0x10, wdata=0xDEADBEEF, mem_req_ready=1 -> mem_be=1111, mem_addr=0x10; with ack in cycle 2, wb_valid in cycle 3, wb_rd=0.
REQ-034 LB addr=0x13, mem_rdata=0x80FF_FF7F -> wb_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-035 SH addr=0x22, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD.
REQ-036 mem_req_ready held at 0 for 5 cycles -> mem_* outputs stable, req_ready=0. Then no response for 255 cycles -> one err pulse, IDLE.
REQ-037 LW addr=0x02 with the macro defined -> err pulse, no mem_req_valid. Without the macro -> mem_addr=0x00, normal completion.
REQ-038 reset_n low during WAIT_RSP -> all outputs at reset values; a late mem_rsp_valid after reset is ignored.
